// File: rtl/fp32_to_fp16_packer_if.sv
// Stream bus for fp32_to_fp16_packer: fp32 element input side and packed fp16 word output side.
interface fp32_to_fp16_packer_if #(parameter int LANES = 4);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_fp32;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*LANES-1:0]   out_data;
    logic [LANES-1:0]      out_mask;
    logic                  out_last;

    modport master (
        output in_valid, in_fp32, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_mask, out_last
    );

    modport slave (
        input  in_valid, in_fp32, in_last, out_ready,
        output in_ready, out_valid, out_data, out_mask, out_last
    );
endinterface

// File: rtl/fp32_to_fp16_packer.sv
// Rounds fp32 elements to fp16 (RNE) and packs LANES of them per output word.
// Define FP16_SUBNORMAL_EN to produce fp16 subnormals; otherwise tiny results flush to signed zero.
module fp32_to_fp16_packer #(
    parameter int LANES = 4
) (
    input logic                   clk,
    input logic                   rst,
    fp32_to_fp16_packer_if.slave  bus
);
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } elem_t;

    function automatic logic [15:0] to_fp16(input logic [31:0] x);
        logic        s;
        logic [7:0]  ex;
        logic [22:0] fr;
        logic        rnd;
        logic [14:0] mag;
`ifdef FP16_SUBNORMAL_EN
        logic [4:0]  sh;
        logic [47:0] ext;
        logic [10:0] q;
`endif
        s   = x[31];
        ex  = x[30:23];
        fr  = x[22:0];
        mag = '0;
        rnd = 1'b0;
        if (ex == 8'hFF)
            mag = (fr != '0) ? 15'h7E00 : 15'h7C00;
        else if (ex >= 8'd143)
            mag = 15'h7C00;
        else if (ex >= 8'd113) begin
            // Exponent field sits above the mantissa, so a rounding carry bumps it (up to Inf).
            rnd = fr[12] & ((|fr[11:0]) | fr[13]);
            mag = {5'(ex - 8'd112), fr[22:13]} + 15'(rnd);
        end
`ifdef FP16_SUBNORMAL_EN
        else if (ex >= 8'd101) begin
            // Units of 2^-24: significand shifted right by 126-exp (14..25).
            sh  = 5'(8'd126 - ex);
            ext = {1'b1, fr, 24'd0} >> sh;
            q   = 11'(ext[47:24]);
            rnd = ext[23] & ((|ext[22:0]) | q[0]);
            mag = {4'd0, q + 11'(rnd)};
        end
`endif
        return {s, mag};
    endfunction

    elem_t                   s1;
    logic                    s1_valid;
    logic [LANES-1:0][15:0]  asm_q;
    logic [LANES-1:0][15:0]  word;
    logic [LANES-1:0]        mask;
    logic [CW-1:0]           cnt;
    logic                    completes;
    logic                    out_free;
    logic                    s1_adv;
    logic                    accept;

    assign completes    = s1.last || (cnt == CW'(LANES - 1));
    assign out_free     = !bus.out_valid || bus.out_ready;
    assign s1_adv       = s1_valid && (!completes || out_free);
    assign bus.in_ready = !s1_valid || s1_adv;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        word = '0;
        mask = '0;
        for (int k = 0; k < LANES; k++) begin
            word[k] = (cnt == CW'(k)) ? s1.data : asm_q[k];
            mask[k] = (k <= int'(cnt));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1            <= '0;
            cnt           <= '0;
            asm_q         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_mask  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1       <= {bus.in_last, to_fp16(bus.in_fp32)};
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                if (completes) begin
                    asm_q <= '0;
                    cnt   <= '0;
                end else begin
                    asm_q[cnt] <= s1.data;
                    cnt        <= cnt + CW'(1);
                end
            end

            // Load and drain may coincide, keeping the output stream bubble-free.
            if (s1_adv && completes) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= word;
                bus.out_mask  <= mask;
                bus.out_last  <= s1.last;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fp32_to_fp16_packer.sv
// Scoreboard bench for fp32_to_fp16_packer (LANES=4); honours FP16_SUBNORMAL_EN for subnormal expectations.
module tb_fp32_to_fp16_packer;
    localparam int LANES = 4;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  m;
        logic        l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    exp_t sb[$];
    bit   saw_stall = 1'b0;

    fp32_to_fp16_packer_if #(.LANES(LANES)) bus();

    fp32_to_fp16_packer #(.LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic [3:0] m, input logic l);
        exp_t e;
        e.d = d;
        e.m = m;
        e.l = l;
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] x, input logic l);
        int t;
        t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_fp32  = x;
        bus.in_last  = l;
        #1;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            vectors++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck 0 for element %h", x);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Monitor: handshake happens at the next posedge, sample just before it.
    initial begin : monitor
        exp_t        e;
        bit          hold;
        logic [63:0] hd;
        logic [3:0]  hm;
        logic        hl;
        hold = 1'b0;
        hd = '0;
        hm = '0;
        hl = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (!bus.in_ready) saw_stall = 1'b1;
                if (hold) begin
                    chk("hold_valid", {95'd0, bus.out_valid}, 96'd1);
                    chk("hold_word", {27'd0, bus.out_last, bus.out_mask, bus.out_data},
                        {27'd0, hl, hm, hd});
                end
                hold = bus.out_valid && !bus.out_ready;
                hd = bus.out_data;
                hm = bus.out_mask;
                hl = bus.out_last;
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL extra_word: got %h mask %b, expected none", bus.out_data, bus.out_mask);
                    end else begin
                        e = sb.pop_front();
                        chk("word", {27'd0, bus.out_last, bus.out_mask, bus.out_data},
                            {27'd0, e.l, e.m, e.d});
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [15:0] sub;
        int          t;
        bus.in_valid  = 1'b0;
        bus.in_fp32   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", {95'd0, bus.out_valid}, 96'd0);
        chk("rst_out_word", {27'd0, bus.out_last, bus.out_mask, bus.out_data}, 96'd0);
        chk("rst_in_ready", {95'd0, bus.in_ready}, 96'd1);
        rst = 1'b0;

        // Rounding, plus 2-cycle latency from the 4th accept
        push(64'hBC00_3C02_3C00_3C00, 4'b1111, 1'b0);
        send(32'h3F800000, 1'b0);
        send(32'h3F801000, 1'b0);
        send(32'h3F803000, 1'b0);
        send(32'hBF800000, 1'b0);
        idle();
        #1;
        chk("lat_cycle1", {95'd0, bus.out_valid}, 96'd0);
        @(negedge clk);
        #1;
        chk("lat_cycle2", {95'd0, bus.out_valid}, 96'd1);

        // Specials; last on lane 3 -> full mask, out_last, no extra word
        push(64'h0000_FC00_7E00_7C00, 4'b1111, 1'b1);
        send(32'h477FF000, 1'b0);
        send(32'h7F800001, 1'b0);
        send(32'hFF800000, 1'b0);
        send(32'h00000001, 1'b1);

        // Subnormal + partial flush on the 3rd element
`ifdef FP16_SUBNORMAL_EN
        sub = 16'h0001;
`else
        sub = 16'h0000;
`endif
        push({16'h0000, 16'h4000, 16'h8000, sub}, 4'b0111, 1'b1);
        send(32'h33800000, 1'b0);
        send(32'hB3000000, 1'b0);
        send(32'h40000000, 1'b1);

        // Next burst restarts at lane 0; last on lane 0
        push(64'h0000_0000_0000_C200, 4'b0001, 1'b1);
        send(32'hC0400000, 1'b1);
        idle();
        repeat (4) @(negedge clk);

        // Backpressure: 12 elements, out_ready low for 10 cycles
        for (int w = 0; w < 3; w++)
            push({16'h3C00 + 16'(4*w+3), 16'h3C00 + 16'(4*w+2),
                  16'h3C00 + 16'(4*w+1), 16'h3C00 + 16'(4*w)}, 4'b1111, 1'b0);
        saw_stall = 1'b0;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++)
                    send(32'h3F800000 + (32'(i) << 13), 1'b0);
                idle();
            end
            begin
                repeat (10) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("bp_drained", {95'd0, sb.size() == 0}, 96'd1);
        chk("bp_in_ready_fell", {95'd0, saw_stall}, 96'd1);

        // Reset mid-word: first two elements must vanish
        send(32'h41000000, 1'b0);
        send(32'h41000000, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_out", {26'd0, bus.out_valid, bus.out_last, bus.out_mask, bus.out_data}, 96'd0);
        chk("midrst_in_ready", {95'd0, bus.in_ready}, 96'd1);
        rst = 1'b0;
        push(64'h0400_7C00_5640_3400, 4'b1111, 1'b0);
        send(32'h3E800000, 1'b0);
        send(32'h42C80000, 1'b0);
        send(32'h7F7FFFFF, 1'b0);
        send(32'h38800000, 1'b0);
        idle();

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("final_drained", {95'd0, sb.size() == 0}, 96'd1);
        repeat (6) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
